// File: rtl/paddle_pot_emu.sv
// N-channel paddle potentiometer emulator: turns digital buttons or signed analog sticks into
// per-channel positions and mimics the RC comparator pin with a per-frame line countdown.
module paddle_pot_emu #(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned POS_W        = 9,
  parameter int unsigned POS_MAX      = 255,
  parameter int unsigned POS_INIT     = 128,
  parameter int unsigned STEP_SLOW    = 5,
  parameter int unsigned STEP_FAST    = 8,
  parameter int unsigned ACCEL_FRAMES = 8
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic                     hs,
  input  logic                     vs,
  input  logic [1:0]               mode,
  input  logic                     speed_fast,
  input  logic [NUM_CH-1:0]        btn_up,
  input  logic [NUM_CH-1:0]        btn_down,
  input  logic [16*NUM_CH-1:0]     analog,
  output logic [POS_W*NUM_CH-1:0]  pos_out,
  output logic [NUM_CH-1:0]        pot_out,
  output logic                     frame_tick
);

  localparam int unsigned HoldW = $clog2(ACCEL_FRAMES + 1);
  localparam int unsigned ExtW  = POS_W + 1;

  typedef logic [POS_W-1:0] pos_t;
  typedef logic [ExtW-1:0]  ext_t;
  typedef logic [HoldW-1:0] hold_t;

  localparam ext_t  PosMax    = ext_t'(POS_MAX);
  localparam pos_t  PosInit   = pos_t'(POS_INIT);
  localparam ext_t  StepSlow  = ext_t'(STEP_SLOW);
  localparam ext_t  StepFast  = ext_t'(STEP_FAST);
  localparam hold_t HoldMax   = hold_t'(ACCEL_FRAMES);

  logic hs_q, vs_q, armed_q, frame_tick_q;
  logic hs_rise, vs_rise;
  logic analog_mode;

  // armed_q keeps a sync level that is already high at reset release from looking like an edge.
  assign hs_rise     = hs & ~hs_q & armed_q;
  assign vs_rise     = vs & ~vs_q & armed_q;
  assign analog_mode = (mode == 2'd1) || (mode == 2'd2);
  assign frame_tick  = frame_tick_q;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      hs_q         <= 1'b0;
      vs_q         <= 1'b0;
      armed_q      <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      hs_q         <= hs;
      vs_q         <= vs;
      armed_q      <= 1'b1;
      frame_tick_q <= vs_rise;
    end
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    pos_t  pos_q, pos_d;
    pos_t  cnt_q, cnt_d;
    hold_t hold_q, hold_d;
    logic  dir_q, dir_d;  // 1 = down, 0 = up

    logic [7:0] a_byte;
    logic       up, dn, same_dir;
    ext_t       v, step, sum, diff;

    always_comb begin
      pos_d  = pos_q;
      cnt_d  = cnt_q;
      hold_d = hold_q;
      dir_d  = dir_q;

      a_byte = (mode == 2'd1) ? analog[ch*16+8 +: 8] : analog[ch*16 +: 8];
      v      = ext_t'({~a_byte[7], a_byte[6:0]});
      if (v > PosMax) begin
        v = PosMax;
      end

      up       = btn_up[ch] & ~btn_down[ch];
      dn       = btn_down[ch] & ~btn_up[ch];
      same_dir = (hold_q != '0) && (dir_q == dn);

      step = speed_fast ? StepFast : StepSlow;
      if (same_dir && (hold_q == HoldMax)) begin
        step = step << 1;
      end
      sum  = ext_t'(pos_q) + step;
      diff = ext_t'(pos_q) - step;

      if (vs_rise) begin
        if (analog_mode) begin
          pos_d  = pos_t'(v);
          cnt_d  = pos_t'(v);
          hold_d = '0;
        end else begin
          // Countdown loads the pre-update position: one frame of lag, as on the real pin.
          cnt_d = pos_q;
          if (up || dn) begin
            dir_d = dn;
            if (!same_dir) begin
              hold_d = hold_t'(1);
            end else if (hold_q != HoldMax) begin
              hold_d = hold_q + hold_t'(1);
            end
            if (up) begin
              pos_d = diff[POS_W] ? '0 : pos_t'(diff);
            end else begin
              pos_d = (sum > PosMax) ? pos_t'(PosMax) : pos_t'(sum);
            end
          end else begin
            hold_d = '0;
          end
        end
      end else if (hs_rise && (cnt_q != '0)) begin
        cnt_d = cnt_q - pos_t'(1);
      end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
        pos_q  <= PosInit;
        cnt_q  <= '0;
        hold_q <= '0;
        dir_q  <= 1'b0;
      end else begin
        pos_q  <= pos_d;
        cnt_q  <= cnt_d;
        hold_q <= hold_d;
        dir_q  <= dir_d;
      end
    end

    assign pos_out[ch*POS_W +: POS_W] = pos_q;
    assign pot_out[ch]                = (cnt_q == '0);
  end

endmodule
